// File: rtl/line_window_ctrl_pkg.sv
// Shared widths and types for the line-buffer control and 3x3 window stage.
package line_window_ctrl_pkg;

    localparam int PIX_W   = 8;
    localparam int WIN_N   = 3;
    localparam int COORD_W = 16;
    localparam int WIN_W   = PIX_W * WIN_N * WIN_N;

    typedef logic [PIX_W-1:0]   pixel_t;
    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

endpackage

// File: rtl/line_window_ctrl_fsm.sv
// Frame-tracking state machine: row/col counters of the pixel being accepted,
// the line-length error flag, and the qualifier that decides whether a pixel is processed.
module line_window_ctrl_fsm
    import line_window_ctrl_pkg::*;
#(
    parameter int LINE_W  = 640,
    parameter int FRAME_H = 480
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   acc,
    input  logic   sof,
    input  logic   eol,
    output logic   proc,
    output coord_t cur_row,
    output coord_t cur_col,
    output logic   line_err
);

    state_t state;
    coord_t row;
    coord_t col;
    logic   last_col;
    logic   line_end;
    logic   frame_end;

    // A start-of-frame pixel is always (0,0) and overrides a simultaneous end-of-line.
    always_comb begin
        cur_row   = sof ? '0 : row;
        cur_col   = sof ? '0 : col;
        proc      = acc && (state == ACTIVE || sof);
        last_col  = (cur_col == coord_t'(LINE_W - 1));
        line_end  = last_col || (eol && !sof);
        frame_end = line_end && (cur_row == coord_t'(FRAME_H - 1));
    end

    // NOTE: registers use non-blocking assignments so every branch sees the pre-edge counter values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WAIT_SOF;
            row      <= '0;
            col      <= '0;
            line_err <= 1'b0;
        end else if (proc) begin
            if (!sof && (eol != last_col))
                line_err <= 1'b1;
            if (frame_end) begin
                state <= WAIT_SOF;
                row   <= '0;
                col   <= '0;
            end else begin
                state <= ACTIVE;
                if (line_end) begin
                    row <= cur_row + 1'b1;
                    col <= '0;
                end else begin
                    row <= cur_row;
                    col <= cur_col + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/line_window_ctrl.sv
// Drives the external two-line buffer and assembles a 3x3 window with center
// coordinates behind a valid/ready output register.
module line_window_ctrl
    import line_window_ctrl_pkg::*;
#(
    parameter int LINE_W  = 640,
    parameter int FRAME_H = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_sof,
    input  logic             s_eol,
    output logic [PIX_W-1:0] lb_d,
    output logic             lb_ce,
    input  logic [PIX_W-1:0] lb_tap1,
    input  logic [PIX_W-1:0] lb_tap2,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIN_W-1:0] m_win,
    output coord_t           m_row,
    output coord_t           m_col,
    output logic             line_err
);

    logic   adv;
    logic   acc;
    logic   proc;
    coord_t cur_row;
    coord_t cur_col;
    pixel_t win [WIN_N][WIN_N];

    assign adv     = !m_valid || m_ready;
    assign acc     = s_valid && adv;
    assign s_ready = adv;
    assign lb_d    = s_data;
    assign lb_ce   = proc;

    line_window_ctrl_fsm #(
        .LINE_W  (LINE_W),
        .FRAME_H (FRAME_H)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .acc      (acc),
        .sof      (s_sof),
        .eol      (s_eol),
        .proc     (proc),
        .cur_row  (cur_row),
        .cur_col  (cur_col),
        .line_err (line_err)
    );

    // NOTE: the window is only nine bytes and is visible on m_win, so it is reset like any other output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_row   <= '0;
            m_col   <= '0;
            for (int r = 0; r < WIN_N; r++)
                for (int c = 0; c < WIN_N; c++)
                    win[r][c] <= '0;
        end else if (adv) begin
            if (proc) begin
                for (int r = 0; r < WIN_N; r++)
                    for (int c = 0; c < WIN_N - 1; c++)
                        win[r][c] <= win[r][c+1];
                win[0][WIN_N-1] <= lb_tap2;
                win[1][WIN_N-1] <= lb_tap1;
                win[2][WIN_N-1] <= s_data;
                m_valid <= (cur_row >= coord_t'(WIN_N - 1)) && (cur_col >= coord_t'(WIN_N - 1));
                m_row   <= cur_row - 1'b1;
                m_col   <= cur_col - 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // NOTE: a default before the loop keeps this block free of inferred latches.
    always_comb begin
        m_win = '0;
        for (int r = 0; r < WIN_N; r++)
            for (int c = 0; c < WIN_N; c++)
                m_win[(r*WIN_N + c)*PIX_W +: PIX_W] = win[r][c];
    end

endmodule

// File: tb/tb_line_window_ctrl.sv
// Bench for line_window_ctrl: behavioural line buffer, write-history window model,
// per-cycle compare process and a few literal expectations for a ramp frame.
module tb_line_window_ctrl;
    import line_window_ctrl_pkg::*;

    localparam int LINE_W  = 8;
    localparam int FRAME_H = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, s_sof, s_eol;
    logic [7:0]  s_data, lb_d, lb_tap1, lb_tap2;
    logic        lb_ce;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [71:0] m_win;
    logic [15:0] m_row, m_col;
    logic        line_err;

    int errors = 0;
    int checks = 0;

    // Stimulus side-band describing the beat currently offered on s_*.
    logic beat_proc = 1'b0;
    logic beat_err  = 1'b0;
    int   beat_r = 0, beat_c = 0;
    bit   bp_mode = 0, gaps_en = 0, img_check = 0, track_first = 0;

    // Written only by the compare process.
    int          win_cnt = 0;
    int          cyc = 0;
    int          acc22_cyc = -1;
    int          first_cyc = -1;
    bit          first_done = 0;
    logic [71:0] first_win = '0;
    logic [15:0] first_row = '0, first_col = '0;

    always #5 clk = ~clk;

    line_window_ctrl #(.LINE_W(LINE_W), .FRAME_H(FRAME_H)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
        .lb_d(lb_d), .lb_ce(lb_ce), .lb_tap1(lb_tap1), .lb_tap2(lb_tap2),
        .m_valid(m_valid), .m_ready(m_ready), .m_win(m_win), .m_row(m_row), .m_col(m_col),
        .line_err(line_err)
    );

    // External two-line shift-register buffer; never reset, so contents go stale across resets.
    logic [7:0] lb_mem [2*LINE_W] = '{default: 8'h00};
    always @(posedge clk) begin
        if (lb_ce) begin
            for (int i = 2*LINE_W-1; i > 0; i--) lb_mem[i] <= lb_mem[i-1];
            lb_mem[0] <= lb_d;
        end
    end
    assign lb_tap1 = lb_mem[LINE_W-1];
    assign lb_tap2 = lb_mem[2*LINE_W-1];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every pixel ever written to the line buffer, oldest first, seeded with the buffer's zero contents.
    logic [7:0] hist[$];

    // Window for the pixel just appended: column k holds write n-2+k and the writes
    // one and two line lengths earlier.
    function automatic logic [71:0] model_window();
        logic [71:0] w;
        int n, j;
        w = '0;
        n = hist.size() - 1;
        for (int k = 0; k < 3; k++) begin
            j = n - 2 + k;
            if (j - 2*LINE_W >= 0) begin
                w[(0*3+k)*8 +: 8] = hist[j - 2*LINE_W];
                w[(1*3+k)*8 +: 8] = hist[j - LINE_W];
                w[(2*3+k)*8 +: 8] = hist[j];
            end
        end
        return w;
    endfunction

    // Compare process: checks outputs against the expected state, then advances it for this cycle's accept.
    logic        exp_valid = 1'b0, exp_err = 1'b0;
    logic [71:0] exp_win = '0;
    logic [15:0] exp_row = '0, exp_col = '0;
    initial begin
        for (int i = 0; i < 2*LINE_W + 2; i++) hist.push_back(8'h00);
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_valid = 1'b0; exp_err = 1'b0; exp_win = '0; exp_row = '0; exp_col = '0;
            end else begin
                bit adv, acc;
                check("m_valid", m_valid, exp_valid);
                if (exp_valid) begin
                    check("m_win", m_win, exp_win);
                    check("m_row", m_row, exp_row);
                    check("m_col", m_col, exp_col);
                end
                check("line_err", line_err, exp_err);
                adv = !exp_valid || m_ready;
                acc = s_valid && adv;
                check("s_ready", s_ready, adv);
                check("lb_ce", lb_ce, acc && beat_proc);
                if (s_valid) check("lb_d", lb_d, s_data);
                if (m_valid && m_ready) begin
                    win_cnt++;
                    if (img_check)
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++) begin
                                logic [7:0] px;
                                px = 8'((int'(exp_row) - 1 + i)*LINE_W + int'(exp_col) - 1 + j);
                                check("image_px", m_win[(3*i+j)*8 +: 8], px);
                            end
                    if (track_first && !first_done) begin
                        first_done = 1; first_cyc = cyc;
                        first_win = m_win; first_row = m_row; first_col = m_col;
                    end
                end
                if (adv) begin
                    if (acc && beat_proc) begin
                        hist.push_back(s_data);
                        if (beat_err) exp_err = 1'b1;
                        exp_valid = (beat_r >= 2) && (beat_c >= 2);
                        exp_row   = 16'(beat_r - 1);
                        exp_col   = 16'(beat_c - 1);
                        exp_win   = model_window();
                        if (track_first && beat_r == 2 && beat_c == 2 && acc22_cyc < 0) acc22_cyc = cyc;
                    end else begin
                        exp_valid = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 m_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input logic sof, input logic eol, input logic [7:0] d,
                        input logic proc, input logic err, input int r, input int c);
        bit took;
        int n;
        if (gaps_en && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_sof = sof; s_eol = eol; s_data = d;
        beat_proc = proc; beat_err = err; beat_r = r; beat_c = c;
        took = 0; n = 0;
        while (!took && n < 200) begin
            @(negedge clk);
            took = s_ready;
            @(posedge clk); #1;
            n++;
        end
        check("accept_timeout", took, 1'b1);
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
        beat_proc = 1'b0; beat_err = 1'b0;
    endtask

    // One frame; short_row ends that line early, sending stops before (stop_r, stop_c).
    task automatic send_frame(input bit ramp, input int short_row, input int short_len,
                              input int stop_r, input int stop_c, output int n_win);
        n_win = 0;
        for (int r = 0; r < FRAME_H; r++) begin
            int len;
            len = (r == short_row) ? short_len : LINE_W;
            for (int c = 0; c < len; c++) begin
                if (r == stop_r && c == stop_c) return;
                send(r == 0 && c == 0, c == len - 1, ramp ? 8'(r*LINE_W + c) : 8'($urandom),
                     1'b1, (c == len - 1) && (len != LINE_W), r, c);
                if (r >= 2 && c >= 2) n_win++;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) begin @(posedge clk); #1; end
        check("drain_m_valid", m_valid, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int base, nw, nw2;
        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values.
        @(negedge clk);
        check("reset_m_valid", m_valid, 1'b0);
        check("reset_m_win", m_win, 72'h0);
        check("reset_m_row", m_row, 16'h0);
        check("reset_m_col", m_col, 16'h0);
        check("reset_line_err", line_err, 1'b0);
        check("reset_s_ready", s_ready, 1'b1);
        check("reset_lb_ce", lb_ce, 1'b0);
        @(posedge clk); #1;

        // Idle pixels without SOF are consumed and dropped.
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0, 0, 0);

        // Clean ramp frame at full rate.
        img_check = 1; track_first = 1; base = win_cnt;
        send_frame(1, -1, 0, -1, -1, nw);
        drain();
        check("full_frame_windows", win_cnt - base, 12);
        check("first_seen", first_done, 1'b1);
        check("first_row", first_row, 16'd1);
        check("first_col", first_col, 16'd1);
        check("first_win", first_win, 72'h12_11_10_0a_09_08_02_01_00);
        check("first_latency", first_cyc - acc22_cyc, 1);
        track_first = 0;
        send(1'b0, 1'b0, 8'h5a, 1'b0, 1'b0, 0, 0);

        // Random backpressure and input gaps over two random frames.
        img_check = 0; bp_mode = 1; gaps_en = 1; base = win_cnt;
        send_frame(0, -1, 0, -1, -1, nw);
        send_frame(0, -1, 0, -1, -1, nw2);
        bp_mode = 0;
        drain();
        check("backpressure_windows", win_cnt - base, nw + nw2);
        gaps_en = 0;

        // Short line: EOL at col 5 sets the sticky error, which survives the next frame.
        base = win_cnt;
        send_frame(0, 1, 6, -1, -1, nw);
        drain();
        check("short_line_err", line_err, 1'b1);
        img_check = 1;
        send_frame(1, -1, 0, -1, -1, nw2);
        drain();
        check("short_line_err_sticky", line_err, 1'b1);
        check("short_line_windows", win_cnt - base, nw + nw2);

        // Mid-frame SOF at (2,3).
        base = win_cnt;
        send_frame(1, -1, 0, 2, 3, nw);
        send_frame(1, -1, 0, -1, -1, nw2);
        drain();
        check("mid_sof_windows", win_cnt - base, 13);

        // Reset at (3,4), then a clean frame.
        send_frame(1, -1, 0, 3, 4, nw);
        do_reset();
        @(negedge clk);
        check("midreset_line_err", line_err, 1'b0);
        check("midreset_m_valid", m_valid, 1'b0);
        @(posedge clk); #1;
        base = win_cnt;
        send_frame(1, -1, 0, -1, -1, nw);
        drain();
        check("after_reset_windows", win_cnt - base, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
